// File: rtl/par_pkg.sv
// Shared constants, types and reference parity helper for the receive-side
// parity checker.
package par_pkg;

  localparam int unsigned DEF_LANES = 4;
  localparam int unsigned DEF_W     = 8;

  typedef logic [DEF_LANES-1:0] lane_flags_t;

  typedef enum logic {RUN, HALT} state_e;

  // Per-lane parity mismatch for a default-geometry word.
  function automatic lane_flags_t lane_parity(
    input logic [DEF_LANES*DEF_W-1:0] data,
    input lane_flags_t                par,
    input logic                       odd
  );
    lane_flags_t res;
    res = '0;
    for (int unsigned i = 0; i < DEF_LANES; i++) begin
      res[i] = (^data[i*DEF_W +: DEF_W]) ^ par[i] ^ odd;
    end
    return res;
  endfunction

endpackage

// File: rtl/par_lane_check.sv
// Combinational parity-mismatch and all-ones detection for one byte lane.
module par_lane_check #(
  parameter int unsigned W   = 8,
  parameter bit          ODD = 1'b0
) (
  input  logic [W-1:0] lane,
  input  logic         par,
  output logic         perr,
  output logic         all_ones
);

  always_comb begin
    perr     = (^lane) ^ par ^ ODD;
    all_ones = &lane;
  end

endmodule

// File: rtl/par_check_unpack.sv
// Receive-side lane parity checker: one-stage registered output with
// handshakes, saturating error count, sticky flag and consecutive-error HALT.
module par_check_unpack
  import par_pkg::*;
#(
  parameter int unsigned LANES     = 4,
  parameter int unsigned W         = 8,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned ERR_LIMIT = 3,
  parameter bit          ODD       = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LANES*W-1:0]   in_data,
  input  logic [LANES-1:0]     in_par,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LANES*W-1:0]   out_data,
  output logic [LANES-1:0]     out_perr,
  output logic [LANES-1:0]     out_all_ones,
  input  logic                 clr,
  output logic [CNT_W-1:0]     err_cnt,
  output logic                 err_sticky,
  output logic                 halted
);

  localparam int unsigned   CW      = $clog2(ERR_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT   = CW'(ERR_LIMIT);
  localparam logic [CW-1:0] LAST_OK = CW'(ERR_LIMIT - 1);

  state_e           state, next_state;
  logic [CW-1:0]    cons_cnt;
  logic [LANES-1:0] perr, all_ones;
  logic             accept, word_err, count_err;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    par_lane_check #(
      .W   (W),
      .ODD (ODD)
    ) u_lane (
      .lane     (in_data[i*W +: W]),
      .par      (in_par[i]),
      .perr     (perr[i]),
      .all_ones (all_ones[i])
    );
  end

  always_comb begin
    next_state = state;
    in_ready   = (state == RUN) && (!out_valid || out_ready);
    accept     = in_valid && in_ready;
    word_err   = |perr;
    // A clear in the same cycle as an erroneous accept suppresses its accounting.
    count_err  = accept && word_err && !clr;
    if (clr) begin
      next_state = RUN;
    end else if (state == RUN && count_err && cons_cnt == LAST_OK) begin
      next_state = HALT;
    end
  end

  assign halted = (state == HALT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cons_cnt   <= '0;
      err_cnt    <= '0;
      err_sticky <= 1'b0;
    end else if (accept) begin
      if (word_err) begin
        cons_cnt   <= (cons_cnt == LIMIT) ? LIMIT : cons_cnt + 1'b1;
        err_sticky <= 1'b1;
        if (err_cnt != '1) begin
          err_cnt <= err_cnt + 1'b1;
        end
      end else begin
        cons_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_perr     <= '0;
      out_all_ones <= '0;
    end else if (accept) begin
      out_valid    <= 1'b1;
      out_data     <= in_data;
      out_perr     <= perr;
      out_all_ones <= all_ones;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_par_check_unpack.sv
// Directed bench for par_check_unpack: default instance plus a CNT_W=2 twin
// driven by the same stimulus for counter saturation.
module tb_par_check_unpack;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready, clr;
  logic [31:0] in_data;
  logic [3:0]  in_par;

  logic        in_ready, out_valid, err_sticky, halted;
  logic [31:0] out_data;
  logic [3:0]  out_perr, out_all_ones;
  logic [15:0] err_cnt;

  logic        in_ready_s, out_valid_s, err_sticky_s, halted_s;
  logic [31:0] out_data_s;
  logic [3:0]  out_perr_s, out_all_ones_s;
  logic [1:0]  err_cnt_s;

  int checks = 0;
  int errors = 0;

  logic [7:0] even_bytes [8] = '{8'h03, 8'h05, 8'h06, 8'h09, 8'h0A, 8'h0C, 8'h0F, 8'h11};

  always #5 clk = ~clk;

  par_check_unpack #(
    .LANES(4), .W(8), .CNT_W(16), .ERR_LIMIT(3), .ODD(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_par(in_par), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_perr(out_perr),
    .out_all_ones(out_all_ones), .clr(clr), .err_cnt(err_cnt),
    .err_sticky(err_sticky), .halted(halted)
  );

  par_check_unpack #(
    .LANES(4), .W(8), .CNT_W(2), .ERR_LIMIT(3), .ODD(1'b0)
  ) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_data(in_data), .in_par(in_par), .out_valid(out_valid_s),
    .out_ready(out_ready), .out_data(out_data_s), .out_perr(out_perr_s),
    .out_all_ones(out_all_ones_s), .clr(clr), .err_cnt(err_cnt_s),
    .err_sticky(err_sticky_s), .halted(halted_s)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [3:0] p);
    in_valid = v;
    in_data  = d;
    in_par   = p;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; out_ready = 1'b1;
    drive(1'b0, 32'h0, 4'h0);
    tick(); tick();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_err_cnt", err_cnt, 16'h0);
    chk("rst_sticky", err_sticky, 1'b0);
    chk("rst_halted", halted, 1'b0);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", in_ready, 1'b1);

    // clean word
    drive(1'b1, 32'h12345678, 4'b0100);
    tick();
    chk("clean_valid", out_valid, 1'b1);
    chk("clean_data", out_data, 32'h12345678);
    chk("clean_perr", out_perr, 4'h0);
    chk("clean_ones", out_all_ones, 4'h0);
    chk("clean_cnt", err_cnt, 16'h0);

    drive(1'b1, 32'hFFFFFFFF, 4'b0000);
    tick();
    chk("ones_flags", out_all_ones, 4'hF);
    chk("ones_perr", out_perr, 4'h0);

    drive(1'b1, 32'h12345678, 4'b0101);
    tick();
    chk("lane_perr", out_perr, 4'b0001);
    chk("lane_cnt", err_cnt, 16'd1);
    chk("lane_sticky", err_sticky, 1'b1);

    drive(1'b1, 32'h00000000, 4'b0000);
    tick();
    chk("zero_perr", out_perr, 4'h0);
    chk("zero_cnt", err_cnt, 16'd1);

    // three consecutive bad words
    drive(1'b1, 32'h12345678, 4'b0101);
    tick();
    drive(1'b1, 32'hFFFFFFFF, 4'b1010);
    tick();
    chk("bad2_perr", out_perr, 4'b1010);
    chk("bad2_halted", halted, 1'b0);
    drive(1'b1, 32'h00FF00FF, 4'b1111);
    tick();
    chk("bad3_perr", out_perr, 4'b1111);
    chk("bad3_halted", halted, 1'b1);
    chk("bad3_in_ready", in_ready, 1'b0);
    chk("bad3_cnt", err_cnt, 16'd4);
    chk("bad3_cnt_sat", err_cnt_s, 2'd3);

    // clean word offered while halted must be refused; output drains
    drive(1'b1, 32'hA5A5A5A5, 4'b0000);
    tick();
    chk("halt_drained", out_valid, 1'b0);
    chk("halt_data_kept", out_data, 32'h00FF00FF);
    chk("halt_in_ready", in_ready, 1'b0);
    tick();
    chk("halt_still", halted, 1'b1);
    chk("halt_no_accept", out_valid, 1'b0);

    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_halted", halted, 1'b0);
    chk("clr_cnt", err_cnt, 16'd0);
    chk("clr_sticky", err_sticky, 1'b0);
    chk("clr_no_accept", out_valid, 1'b0);
    tick();
    chk("resume_data", out_data, 32'hA5A5A5A5);
    chk("resume_valid", out_valid, 1'b1);

    // bad word concurrent with clr: data registered, error not counted
    drive(1'b1, 32'h12345678, 4'b0101);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clrwin_data", out_data, 32'h12345678);
    chk("clrwin_perr", out_perr, 4'b0001);
    chk("clrwin_cnt", err_cnt, 16'd0);
    chk("clrwin_sticky", err_sticky, 1'b0);

    // backpressure
    out_ready = 1'b0;
    drive(1'b1, {4{even_bytes[0]}}, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_in_ready", in_ready, 1'b0);
      tick();
      chk("bp_data_stable", out_data, 32'h12345678);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("stream_valid", out_valid, 1'b1);
      chk("stream_data", out_data, {4{even_bytes[k]}});
      if (k < 7) drive(1'b1, {4{even_bytes[k+1]}}, 4'b0000);
      else drive(1'b0, 32'h0, 4'b0000);
    end
    tick();
    chk("stream_end", out_valid, 1'b0);
    chk("stream_cnt", err_cnt, 16'd0);

    // 5 bad words interleaved with clean ones
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h12345678, 4'b0101);
      tick();
      drive(1'b1, 32'h12345678, 4'b0100);
      tick();
    end
    chk("sat_cnt_small", err_cnt_s, 2'd3);
    chk("sat_cnt_wide", err_cnt, 16'd5);
    chk("sat_halted", halted, 1'b0);
    chk("sat_valid", out_valid, 1'b1);

    // reset with a word held
    drive(1'b0, 32'h0, 4'b0000);
    out_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_valid", out_valid, 1'b0);
    chk("rst2_data", out_data, 32'h0);
    chk("rst2_perr", out_perr, 4'h0);
    chk("rst2_ones", out_all_ones, 4'h0);
    chk("rst2_cnt", err_cnt, 16'h0);
    chk("rst2_cnt_small", err_cnt_s, 2'd0);
    chk("rst2_sticky", err_sticky, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
